div_seq_restoring: RTL and testbench

//  Multi-cycle unsigned restoring divider. It is the sequential stage that

---
 rtl/div_seq_restoring.sv | 109 ++++++++++
 tb/tb_div_seq_restoring.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/div_seq_restoring.sv
// Sequential unsigned restoring divider.
// One quotient bit per clock, MSB first.
module div_seq_restoring #(
   parameter int WIDTH = 8
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             valid_i,
   output logic             ready_o,
   input  logic [WIDTH-1:0] dividend_i,
   input  logic [WIDTH-1:0] divisor_i,
   output logic             valid_o,
   input  logic             ready_i,
   output logic [WIDTH-1:0] quotient_o,
   output logic [WIDTH-1:0] remainder_o,
   output logic             div_by_zero_o
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      DONE
   } state_t;

   state_t           state_q;
   logic [WIDTH-1:0] q_q;
   logic [WIDTH-1:0] d_q;
   // Partial remainder stays below the divisor, so its top bit is always
   // zero and only the low WIDTH bits are kept.
   logic [WIDTH-1:0] r_q;
   logic [CW-1:0]    cnt_q;

   logic [WIDTH:0]   sh;
   logic [WIDTH:0]   t;
   logic             qbit;
   logic [WIDTH-1:0] r_nx;
   logic [WIDTH-1:0] q_nx;

   assign ready_o = (state_q == IDLE);

   // One restoring subtract row, reused every CALC cycle
   always_comb begin
      sh   = {r_q, q_q[WIDTH-1]};
      t    = sh - {1'b0, d_q};
      qbit = ~t[WIDTH];
      r_nx = qbit ? t[WIDTH-1:0] : sh[WIDTH-1:0];
      q_nx = {q_q[WIDTH-2:0], qbit};
   end

   // Control FSM, iteration datapath and registered result
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q       <= IDLE;
         q_q           <= '0;
         d_q           <= '0;
         r_q           <= '0;
         cnt_q         <= '0;
         valid_o       <= 1'b0;
         quotient_o    <= '0;
         remainder_o   <= '0;
         div_by_zero_o <= 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (valid_i) begin
                  q_q           <= dividend_i;
                  d_q           <= divisor_i;
                  r_q           <= '0;
                  cnt_q         <= CW'(WIDTH);
                  div_by_zero_o <= 1'b0;
                  if (divisor_i == '0) begin
                     state_q       <= DONE;
                     valid_o       <= 1'b1;
                     quotient_o    <= '1;
                     remainder_o   <= dividend_i;
                     div_by_zero_o <= 1'b1;
                  end else begin
                     state_q <= CALC;
                  end
               end
            end
            CALC: begin
               q_q   <= q_nx;
               r_q   <= r_nx;
               cnt_q <= cnt_q - CW'(1);
               if (cnt_q == CW'(1)) begin
                  state_q     <= DONE;
                  valid_o     <= 1'b1;
                  quotient_o  <= q_nx;
                  remainder_o <= r_nx;
               end
            end
            DONE: begin
               if (ready_i) begin
                  state_q <= IDLE;
                  valid_o <= 1'b0;
               end
            end
            default: begin
               state_q <= IDLE;
               valid_o <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_div_seq_restoring.sv
// Bench for div_seq_restoring.
// Scoreboard of expected results, random consumer stalls.
module tb_div_seq_restoring;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst_i;
   logic         valid_i;
   logic         ready_o;
   logic [W-1:0] dividend_i;
   logic [W-1:0] divisor_i;
   logic         valid_o;
   logic         ready_i;
   logic [W-1:0] quotient_o;
   logic [W-1:0] remainder_o;
   logic         div_by_zero_o;

   div_seq_restoring #(.WIDTH(W)) dut (
      .clk_i         (clk),
      .rst_i         (rst_i),
      .valid_i       (valid_i),
      .ready_o       (ready_o),
      .dividend_i    (dividend_i),
      .divisor_i     (divisor_i),
      .valid_o       (valid_o),
      .ready_i       (ready_i),
      .quotient_o    (quotient_o),
      .remainder_o   (remainder_o),
      .div_by_zero_o (div_by_zero_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      int a;
      int b;
      int q;
      int r;
      int z;
      int acc;
      int lat;
   } item_t;

   item_t sbq[$];

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int hold  = 0;
   bit bp_rand = 1'b0;
   bit bp_arm  = 1'b0;
   bit prev_v  = 1'b0;
   bit rdy_nxt = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input int got, input int exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
      end
   endtask

   // Consumer side: drives ready_i and checks results against the queue
   always @(negedge clk) begin
      item_t e;
      bit    rise;
      rise = valid_o && !prev_v;
      if (rise && bp_arm) begin
         hold   = 5;
         bp_arm = 1'b0;
      end
      if (hold > 0) begin
         ready_i = 1'b0;
         hold--;
      end else begin
         ready_i = bp_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
      end
      if (rdy_nxt) begin
         check("ready_after_handoff", ready_o, 1);
         rdy_nxt = 1'b0;
      end
      if (valid_o) begin
         if (sbq.size() == 0) begin
            check("spurious_valid", valid_o, 0);
         end else begin
            e = sbq[0];
            check("quotient", quotient_o, e.q);
            check("remainder", remainder_o, e.r);
            check("div_by_zero", div_by_zero_o, e.z);
            check("ready_busy", ready_o, 0);
            if (rise) begin
               check("latency", cyc - e.acc, e.lat);
               if (e.z == 0) begin
                  check("invariant",
                        int'(quotient_o) * e.b + int'(remainder_o), e.a);
                  check("rem_lt_div", int'(remainder_o) < e.b, 1);
               end
            end
            if (ready_i) begin
               void'(sbq.pop_front());
               rdy_nxt = 1'b1;
            end
         end
      end
      prev_v = valid_o;
   end

   // Present operands, wait for ready_o, record expected result
   task automatic do_op(input int a, input int b);
      item_t e;
      int    n;
      n          = 0;
      valid_i    = 1'b1;
      dividend_i = W'(a);
      divisor_i  = W'(b);
      @(negedge clk);
      while (!ready_o && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!ready_o) begin
         check("accept_timeout", ready_o, 1);
         valid_i = 1'b0;
         return;
      end
      e.a   = a;
      e.b   = b;
      e.q   = (b == 0) ? 255 : a / b;
      e.r   = (b == 0) ? a : a % b;
      e.z   = (b == 0) ? 1 : 0;
      e.acc = cyc + 1;
      e.lat = (b == 0) ? 0 : W;
      sbq.push_back(e);
      @(posedge clk);
      #1;
      valid_i    = 1'b0;
      dividend_i = W'($urandom);
      divisor_i  = W'($urandom);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((sbq.size() != 0 || !ready_o) && n < 600) begin
         @(negedge clk);
         n++;
      end
      check("drain", sbq.size(), 0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      int a;
      int b;
      rst_i      = 1'b1;
      valid_i    = 1'b0;
      dividend_i = '0;
      divisor_i  = '0;
      ready_i    = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst_i = 1'b0;
      @(negedge clk);
      check("rst_ready", ready_o, 1);
      check("rst_valid", valid_o, 0);
      check("rst_q", quotient_o, 0);
      check("rst_r", remainder_o, 0);
      check("rst_dbz", div_by_zero_o, 0);
      @(posedge clk);
      #1;

      do_op(100, 7);
      drain();
      do_op(255, 1);
      do_op(5, 9);
      do_op(255, 255);
      do_op(0, 3);
      drain();
      do_op(42, 0);
      drain();

      bp_arm = 1'b1;
      do_op(200, 3);
      do_op(9, 9);
      drain();

      do_op(100, 7);
      repeat (3) @(posedge clk);
      #1;
      rst_i = 1'b1;
      @(posedge clk);
      #1;
      rst_i = 1'b0;
      sbq.delete();
      @(negedge clk);
      check("abort_ready", ready_o, 1);
      check("abort_valid", valid_o, 0);
      check("abort_q", quotient_o, 0);
      check("abort_r", remainder_o, 0);
      check("abort_dbz", div_by_zero_o, 0);
      @(posedge clk);
      #1;
      do_op(9, 2);
      drain();

      bp_rand = 1'b1;
      for (int i = 0; i < 1000; i++) begin
         a = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, 255));
         b = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, 255));
         do_op(a, b);
      end
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
